// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: parametrised Moore serial pattern detector.
//
// Tracks the longest prefix of PATTERN matched so far (state 0..LEN) on a
// qualified serial bit stream. The transition table is built at elaboration,
// so the runtime logic is a table lookup plus a state register.
//
// Ports:
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset
//   in_valid    qualifies in; state holds when low
//   in          serial data bit (MSB of PATTERN arrives first)
//   restart     synchronous FSM restart (counter unaffected)
//   clr_cnt     synchronous match counter clear
//   out         Moore match flag, high iff state == LEN
//   match_count saturating count of entries into state LEN
//   state       current state (debug)
module seq_detect_fsm #(
  parameter int unsigned LEN = 3,
  parameter logic [LEN-1:0] PATTERN = 3'b101,
  parameter bit OVERLAP = 1'b1,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned STATE_W = $clog2(LEN + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  input  logic               in,
  input  logic               restart,
  input  logic               clr_cnt,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic [STATE_W-1:0] state
);

  if (LEN < 1 || LEN > 16) begin : g_len_chk
    $error("seq_detect_fsm: LEN must be in 1..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_cnt_chk
    $error("seq_detect_fsm: CNT_W must be in 1..32");
  end

  localparam int unsigned TAB_W = 2 * (LEN + 1) * STATE_W;

  // Pattern bit i counted from the first-received bit (i = 0 is the MSB).
  function automatic logic pbit(input int unsigned i);
    logic [LEN-1:0] t;
    t = PATTERN >> (LEN - 1 - i);
    return t[0];
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of prefix_k.
  function automatic int unsigned fail_len(input int unsigned k);
    int unsigned best;
    bit ok;
    best = 0;
    for (int unsigned j = 1; j < k; j++) begin
      ok = 1'b1;
      for (int unsigned m = 0; m < j; m++) begin
        if (pbit(k - j + m) != pbit(m)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  // Longest pattern prefix that is a suffix of (prefix_b followed by x).
  // Covers both the advance case (result b+1) and the fallback case.
  function automatic int unsigned next_of(input int unsigned b, input bit x);
    int unsigned best;
    int unsigned i;
    bit ok;
    logic sb;
    best = 0;
    for (int unsigned j = 1; j <= b + 1; j++) begin
      ok = 1'b1;
      for (int unsigned m = 0; m < j; m++) begin
        i  = b + 1 - j + m;
        sb = (i == b) ? logic'(x) : pbit(i);
        if (sb != pbit(m)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  // Entry for (state k, bit x) lives at bit offset (2*k + x) * STATE_W.
  function automatic logic [TAB_W-1:0] build_tab();
    logic [TAB_W-1:0] t;
    int unsigned base_full;
    int unsigned b;
    t = '0;
    base_full = OVERLAP ? fail_len(LEN) : 0;
    for (int unsigned k = 0; k <= LEN; k++) begin
      for (int unsigned x = 0; x < 2; x++) begin
        b = (k == LEN) ? base_full : k;
        t = t | (TAB_W'(next_of(b, x == 1)) << ((2 * k + x) * STATE_W));
      end
    end
    return t;
  endfunction

  localparam logic [TAB_W-1:0]   TRANS   = build_tab();
  localparam logic [STATE_W-1:0] LEN_S   = STATE_W'(LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] base, nxt;
  int unsigned        idx;
  logic               hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit     = 1'b0;
    // Unreachable encodings above LEN fall back to the empty state.
    base    = (state_q > LEN_S) ? '0 : state_q;
    idx     = (32'(base) * 2 + 32'(in)) * STATE_W;
    nxt     = STATE_W'(TRANS >> idx);

    if (restart) begin
      state_d = '0;
    end else if (in_valid) begin
      state_d = nxt;
      hit     = (nxt == LEN_S);
    end

    // Clear first, then the increment, so clear+match leaves a count of 1.
    if (clr_cnt) cnt_d = '0;
    if (hit && cnt_d != CNT_MAX) cnt_d = cnt_d + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out         = (state_q == LEN_S);
  assign match_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed and randomised checks for seq_detect_fsm with three parameter sets:
// default "101" overlapping, "101" non-overlapping, and "11" with a 2-bit count.
module tb_seq_detect_fsm;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic in_valid = 1'b0;
  logic din = 1'b0;
  logic restart = 1'b0;
  logic clr_cnt = 1'b0;

  logic       def_out, nov_out, p11_out;
  logic [7:0] def_cnt, nov_cnt;
  logic [1:0] p11_cnt;
  logic [1:0] def_st, nov_st, p11_st;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_detect_fsm u_def (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in(din), .restart(restart),
    .clr_cnt(clr_cnt), .out(def_out), .match_count(def_cnt), .state(def_st)
  );

  seq_detect_fsm #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in(din), .restart(restart),
    .clr_cnt(clr_cnt), .out(nov_out), .match_count(nov_cnt), .state(nov_st)
  );

  seq_detect_fsm #(.LEN(2), .PATTERN(2'b11), .CNT_W(2)) u_p11 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in(din), .restart(restart),
    .clr_cnt(clr_cnt), .out(p11_out), .match_count(p11_cnt), .state(p11_st)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply one edge worth of inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic v, input logic b, input logic rs, input logic clr);
    in_valid = v;
    din      = b;
    restart  = rs;
    clr_cnt  = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    restart  = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    in_valid = 1'b0;
    restart  = 1'b0;
    clr_cnt  = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;
  endtask

  logic       bits5   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] def_st5 [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
  logic [7:0] def_cn5 [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
  logic [1:0] nov_st5 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [7:0] nov_cn5 [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
  logic [1:0] p11_st6 [6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
  logic [1:0] p11_cn6 [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  logic [2:0] hist;
  int         exp_cnt;
  logic       v, b;

  initial begin
    // Reset state
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("rst def state", def_st, 0);
    check("rst def out", def_out, 0);
    check("rst def count", def_cnt, 0);
    check("rst p11 count", p11_cnt, 0);
    do_reset();

    // 1,0,1,0,1 with overlap and without
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bits5[i], 1'b0, 1'b0);
      check($sformatf("t1 def state[%0d]", i), def_st, def_st5[i]);
      check($sformatf("t1 def out[%0d]", i), def_out, def_st5[i] == 2'd3);
      check($sformatf("t1 def count[%0d]", i), def_cnt, def_cn5[i]);
      check($sformatf("t1 nov state[%0d]", i), nov_st, nov_st5[i]);
      check($sformatf("t1 nov out[%0d]", i), nov_out, nov_st5[i] == 2'd3);
      check($sformatf("t1 nov count[%0d]", i), nov_cnt, nov_cn5[i]);
    end

    // Stall with in toggling while in_valid is low
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("t3 pre-stall state", def_st, 2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
      check($sformatf("t3 stall state[%0d]", i), def_st, 2);
      check($sformatf("t3 stall count[%0d]", i), def_cnt, 0);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("t3 final state", def_st, 3);
    check("t3 final out", def_out, 1);
    check("t3 final count", def_cnt, 1);

    // "11" with six ones, saturation at 3, then clear alongside a match
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check($sformatf("t4 p11 state[%0d]", i), p11_st, p11_st6[i]);
      check($sformatf("t4 p11 out[%0d]", i), p11_out, i >= 1);
      check($sformatf("t4 p11 count[%0d]", i), p11_cnt, p11_cn6[i]);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("t4 clr+match count", p11_cnt, 1);
    check("t4 clr+match out", p11_out, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("t4 clr only count", p11_cnt, 0);

    // Asynchronous reset between edges
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, bits5[i], 1'b0, 1'b0);
    check("t5 pre-reset state", def_st, 2);
    check("t5 pre-reset count", def_cnt, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("t5 async state", def_st, 0);
    check("t5 async out", def_out, 0);
    check("t5 async count", def_cnt, 0);
    resetn = 1'b1;

    // Restart from state 2 with a matching bit present
    for (int i = 0; i < 4; i++) drive(1'b1, bits5[i], 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("t5 restart state", def_st, 0);
    check("t5 restart count", def_cnt, 1);
    for (int i = 0; i < 3; i++) drive(1'b1, bits5[i], 1'b0, 1'b0);
    check("t5 rematch state", def_st, 3);
    check("t5 rematch count", def_cnt, 2);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    check("t5 restart+clr state", def_st, 0);
    check("t5 restart+clr count", def_cnt, 0);

    // Random stream against a sliding-window model of overlapping "101"
    do_reset();
    hist    = 3'b000;
    exp_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      v = ($urandom_range(0, 9) != 0);
      b = 1'($urandom_range(0, 1));
      drive(v, b, 1'b0, 1'b0);
      if (v) begin
        hist = {hist[1:0], b};
        if (hist == 3'b101 && exp_cnt < 255) exp_cnt++;
      end
      check($sformatf("t6 out[%0d]", i), def_out, hist == 3'b101);
      check($sformatf("t6 count[%0d]", i), def_cnt, exp_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
